// File: rtl/fir_pkg.sv
// Shared constants and requantisation helper for the FIR output chain.
// No ports. Exports:
//   FIR_IN_W / FIR_OUT_W / FIR_COEF_SHIFT  - accumulator width, sample width, Q15 shift
//   sat_round_t                            - clamped sample plus saturation flag
//   sat_round(x, shift)                    - round-half-up, arithmetic shift, clamp
package fir_pkg;

  localparam int unsigned FIR_IN_W       = 32;
  localparam int unsigned FIR_OUT_W      = 16;
  localparam int unsigned FIR_COEF_SHIFT = 15;

  typedef struct packed {
    logic signed [FIR_OUT_W-1:0] value;
    logic                        sat;
  } sat_round_t;

  // shift must be in 1..FIR_IN_W-1; the extra MSB keeps the rounding add from overflowing.
  function automatic sat_round_t sat_round(input logic signed [FIR_IN_W-1:0] x,
                                           input int unsigned              shift);
    logic signed [FIR_IN_W:0] ext;
    logic signed [FIR_IN_W:0] r;
    logic signed [FIR_IN_W:0] max_v;
    logic signed [FIR_IN_W:0] min_v;
    sat_round_t               res;
    ext   = {x[FIR_IN_W-1], x};
    r     = (ext + $signed((FIR_IN_W+1)'(1) << (shift - 1))) >>> shift;
    max_v = $signed(((FIR_IN_W+1)'(1) << (FIR_OUT_W - 1)) - (FIR_IN_W+1)'(1));
    min_v = ~max_v;
    res.sat = 1'b0;
    if (r > max_v) begin
      res.value = max_v[FIR_OUT_W-1:0];
      res.sat   = 1'b1;
    end else if (r < min_v) begin
      res.value = min_v[FIR_OUT_W-1:0];
      res.sat   = 1'b1;
    end else begin
      res.value = r[FIR_OUT_W-1:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/fir_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with a registered head word.
// Ports:
//   clk_i, rst_ni      - clock, asynchronous active-low reset
//   push_i, data_i     - write strobe and data (caller guarantees no overflow)
//   pop_i              - consume head word; ignored while empty
//   data_o             - registered head; holds its last value when empty
//   full_o, empty_o    - status flags
//   count_o            - occupancy, 0..DEPTH
module fir_sync_fifo #(
  parameter  int unsigned WIDTH = 16,
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned CW    = AW + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0]    cnt_q, cnt_d, cnt_pop;
  logic [WIDTH-1:0] head_q, head_d;
  logic             do_pop;

  always_comb begin
    do_pop  = pop_i && (cnt_q != '0);
    rd_d    = rd_q + AW'(do_pop);
    wr_d    = wr_q + AW'(push_i);
    cnt_pop = cnt_q - CW'(do_pop);
    cnt_d   = cnt_pop + CW'(push_i);
    // Head is re-fetched every edge that leaves data behind; if the pop
    // drained the storage, the word being pushed becomes the head directly.
    head_d  = head_q;
    if (cnt_d != '0) begin
      head_d = (cnt_pop == '0) ? data_i : mem_q[rd_d];
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i) begin
      mem_q[wr_q] <= data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_q   <= '0;
      wr_q   <= '0;
      cnt_q  <= '0;
      head_q <= '0;
    end else begin
      rd_q   <= rd_d;
      wr_q   <= wr_d;
      cnt_q  <= cnt_d;
      head_q <= head_d;
    end
  end

  assign data_o  = head_q;
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;

endmodule

// File: rtl/fir_decim_requant.sv
// Decimator and requantiser behind the FIR filter.
// Keeps the sample accepted at phase 0 of every DECIM, rounds it (half-up),
// arithmetic-shifts by SHIFT, clamps to OUT_W bits and queues it in a small
// FWFT FIFO. Saturation events are counted.
// Ports:
//   clk, rst (async, active-low)
//   in_valid/in_data/in_ready     - upstream handshake, IN_W-bit signed samples
//   out_valid/out_data/out_ready  - downstream handshake, OUT_W-bit signed samples
//   clr_sat                       - synchronous clear of sat_count (beats increment)
//   sat_count                     - saturating count of clamped kept samples
//   phase                         - current decimation phase (debug)
module fir_decim_requant
  import fir_pkg::*;
#(
  parameter  int unsigned IN_W  = FIR_IN_W,
  parameter  int unsigned OUT_W = FIR_OUT_W,
  parameter  int unsigned SHIFT = FIR_COEF_SHIFT,
  parameter  int unsigned DECIM = 4,
  parameter  int unsigned DEPTH = 4,
  parameter  int unsigned CNT_W = 16,
  localparam int unsigned PH_W  = (DECIM > 1) ? $clog2(DECIM) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [IN_W-1:0]  in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [OUT_W-1:0] out_data,
  input  logic             out_ready,
  input  logic             clr_sat,
  output logic [CNT_W-1:0] sat_count,
  output logic [PH_W-1:0]  phase
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic signed [IN_W:0] RND  = $signed((IN_W+1)'(1) << (SHIFT - 1));
  localparam logic signed [IN_W:0] MAXV = $signed(((IN_W+1)'(1) << (OUT_W - 1)) - (IN_W+1)'(1));
  localparam logic signed [IN_W:0] MINV = ~MAXV;

  logic [PH_W-1:0]        phase_q, phase_d;
  logic                   p_valid_q, p_valid_d;
  logic signed [IN_W:0]   r_q, r_d;
  logic signed [IN_W:0]   in_ext;
  logic [CNT_W-1:0]       sat_count_q, sat_count_d;
  logic                   accept, keep;
  logic                   sat_hi, sat_lo, sat_hit;
  logic [OUT_W-1:0]       s_d;
  logic                   fifo_full, fifo_empty;
  logic [CW-1:0]          fifo_count;

  // Stage 1: decimation and round/shift on the input edge.
  always_comb begin
    in_ready  = ({1'b0, fifo_count} + {{CW{1'b0}}, p_valid_q}) < (CW+1)'(DEPTH);
    accept    = in_valid && in_ready;
    keep      = (phase_q == '0);
    in_ext    = {in_data[IN_W-1], in_data};
    r_d       = (in_ext + RND) >>> SHIFT;
    p_valid_d = accept && keep;
    phase_d   = phase_q;
    if (accept) begin
      phase_d = (phase_q == PH_W'(DECIM - 1)) ? '0 : phase_q + 1'b1;
    end
  end

  // Stage 2: clamp into the FIFO and count saturations.
  always_comb begin
    sat_hi  = (r_q > MAXV);
    sat_lo  = (r_q < MINV);
    sat_hit = p_valid_q && (sat_hi || sat_lo);
    if (sat_hi) begin
      s_d = MAXV[OUT_W-1:0];
    end else if (sat_lo) begin
      s_d = MINV[OUT_W-1:0];
    end else begin
      s_d = r_q[OUT_W-1:0];
    end
    sat_count_d = sat_count_q;
    if (clr_sat) begin
      sat_count_d = '0;
    end else if (sat_hit && (sat_count_q != '1)) begin
      sat_count_d = sat_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase_q     <= '0;
      p_valid_q   <= 1'b0;
      r_q         <= '0;
      sat_count_q <= '0;
    end else begin
      phase_q     <= phase_d;
      p_valid_q   <= p_valid_d;
      if (p_valid_d) begin
        r_q <= r_d;
      end
      sat_count_q <= sat_count_d;
    end
  end

  fir_sync_fifo #(
    .WIDTH (OUT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (rst),
    .push_i  (p_valid_q),
    .data_i  (s_d),
    .pop_i   (out_ready),
    .data_o  (out_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign out_valid = !fifo_empty;
  assign sat_count = sat_count_q;
  assign phase     = phase_q;

  // A pop in the same cycle frees the slot, so only push-without-pop into a full FIFO is illegal.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
    !(fifo_full && p_valid_q && !out_ready));

endmodule

// File: tb/tb_fir_decim_requant.sv
// Scoreboard bench: two instances (DECIM=1 with default counter, DECIM=4 with a
// 2-bit saturation counter). Drivers push reference results on accept; one
// monitor per instance pops and compares whenever a word leaves the DUT.
module tb_fir_decim_requant;

  typedef struct {
    int data;
    int acc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in_data;
  logic        in_valid1, in_valid4;
  logic        out_ready;
  logic        clr_sat;

  logic        in_ready1, out_valid1;
  logic [15:0] out_data1, sat1;
  logic [0:0]  phase1;
  logic        in_ready4, out_valid4;
  logic [15:0] out_data4;
  logic [1:0]  sat4, phase4;

  int   checks = 0, failures = 0;
  int   cyc = 0;
  exp_t q1[$], q4[$];
  int   m_sat1 = 0, m_sat4 = 0, m_ph4 = 0;
  int   n_acc1 = 0, n_out4 = 0, stalls1 = 0;
  bit   lat_chk = 1'b0;

  fir_decim_requant #(.DECIM(1)) u_d1 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid1),
    .in_data   (in_data),
    .in_ready  (in_ready1),
    .out_valid (out_valid1),
    .out_data  (out_data1),
    .out_ready (out_ready),
    .clr_sat   (clr_sat),
    .sat_count (sat1),
    .phase     (phase1)
  );

  fir_decim_requant #(.DECIM(4), .CNT_W(2)) u_d4 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid4),
    .in_data   (in_data),
    .in_ready  (in_ready4),
    .out_valid (out_valid4),
    .out_data  (out_data4),
    .out_ready (out_ready),
    .clr_sat   (clr_sat),
    .sat_count (sat4),
    .phase     (phase4)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog actual=still_running required=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Reference: floor((x + 2^14) / 2^15), then clamp to 16-bit signed.
  function automatic int ref_q(input int x, output bit sat);
    longint v, q;
    v = longint'(x) + 16384;
    if (v >= 0) q = v / 32768;
    else        q = -((-v + 32767) / 32768);
    sat = 1'b0;
    if (q > 32767) begin
      q = 32767;  sat = 1'b1;
    end else if (q < -32768) begin
      q = -32768; sat = 1'b1;
    end
    return int'(q);
  endfunction

  task automatic accept1(input logic [31:0] x);
    bit s;
    int e;
    e = ref_q(x, s);
    q1.push_back('{e, cyc + 1});
    if (s && m_sat1 < 65535) m_sat1++;
    n_acc1++;
  endtask

  task automatic accept4(input logic [31:0] x);
    bit s;
    int e;
    e = ref_q(x, s);
    if (m_ph4 == 0) begin
      q4.push_back('{e, cyc + 1});
      if (s && m_sat4 < 3) m_sat4++;
    end
    m_ph4 = (m_ph4 + 1) % 4;
  endtask

  task automatic send1(input logic [31:0] x);
    int unsigned w;
    w = 0;
    @(negedge clk);
    in_data = x; in_valid1 = 1'b1;
    #1;
    while (!in_ready1 && w < 100) begin
      stalls1++;
      @(negedge clk); #1;
      w++;
    end
    if (in_ready1) accept1(x);
    else begin
      checks++; failures++;
      $display("FAIL d1_send_timeout actual=in_ready_low required=in_ready_high");
      in_valid1 = 1'b0;
    end
  endtask

  task automatic send4(input logic [31:0] x);
    int unsigned w;
    w = 0;
    @(negedge clk);
    in_data = x; in_valid4 = 1'b1;
    #1;
    while (!in_ready4 && w < 100) begin
      @(negedge clk); #1;
      w++;
    end
    if (in_ready4) accept4(x);
    else begin
      checks++; failures++;
      $display("FAIL d4_send_timeout actual=in_ready_low required=in_ready_high");
      in_valid4 = 1'b0;
    end
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid1 = 1'b0; in_valid4 = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  initial begin : mon1
    exp_t        e;
    bit          stall;
    logic [15:0] held;
    stall = 1'b0; held = '0;
    forever begin
      @(negedge clk); #1;
      if (!rst) stall = 1'b0;
      else begin
        if (stall) begin
          check("d1_stall_valid", out_valid1, 1);
          check("d1_stall_hold", out_data1, held);
        end
        if (out_valid1 && out_ready) begin
          if (q1.size() == 0) begin
            checks++; failures++;
            $display("FAIL d1_unexpected_output actual=%0d required=none", $signed(out_data1));
          end else begin
            e = q1.pop_front();
            check("d1_data", $signed(out_data1), e.data);
            if (lat_chk) check("d1_latency", cyc - e.acc, 1);
          end
        end
        stall = out_valid1 && !out_ready;
        held  = out_data1;
      end
    end
  end

  initial begin : mon4
    exp_t        e;
    bit          stall;
    logic [15:0] held;
    stall = 1'b0; held = '0;
    forever begin
      @(negedge clk); #1;
      if (!rst) stall = 1'b0;
      else begin
        if (stall) begin
          check("d4_stall_valid", out_valid4, 1);
          check("d4_stall_hold", out_data4, held);
        end
        if (out_valid4 && out_ready) begin
          n_out4++;
          if (q4.size() == 0) begin
            checks++; failures++;
            $display("FAIL d4_unexpected_output actual=%0d required=none", $signed(out_data4));
          end else begin
            e = q4.pop_front();
            check("d4_data", $signed(out_data4), e.data);
          end
        end
        stall = out_valid4 && !out_ready;
        held  = out_data4;
      end
    end
  end

  initial begin : stim
    int          base;
    logic [31:0] r, x;
    rst = 1'b0; in_data = '0; in_valid1 = 1'b0; in_valid4 = 1'b0;
    out_ready = 1'b1; clr_sat = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    tick(1);
    check("rst_d1_out_valid", out_valid1, 0);
    check("rst_d1_out_data", out_data1, 0);
    check("rst_d1_sat", sat1, 0);
    check("rst_d1_phase", phase1, 0);
    check("rst_d1_in_ready", in_ready1, 1);
    check("rst_d4_out_valid", out_valid4, 0);
    check("rst_d4_out_data", out_data4, 0);
    check("rst_d4_sat", sat4, 0);
    check("rst_d4_phase", phase4, 0);
    check("rst_d4_in_ready", in_ready4, 1);

    // Rounding, two-cycle latency.
    lat_chk = 1'b1;
    send1(32'd32768); send1(32'd16384); send1(-32'sd16384); send1(-32'sd16385);
    idle();
    tick(5);
    lat_chk = 1'b0;
    check("d1_sat_after_round", sat1, 0);

    // Saturation both ways, then a clear coincident with a third saturation.
    send1(32'h7FFF_FFFF); send1(32'h8000_0000);
    idle();
    tick(4);
    check("d1_sat_count_two", sat1, 2);
    send1(32'h7FFF_FFFF);
    @(negedge clk);
    in_valid1 = 1'b0; clr_sat = 1'b1;
    @(negedge clk);
    clr_sat = 1'b0; m_sat1 = 0;
    tick(3);
    check("d1_sat_clear_wins", sat1, m_sat1);

    // Decimation by 4.
    base = n_out4;
    for (int k = 1; k <= 8; k++) send4(k * 32768);
    idle();
    tick(6);
    check("d4_decim_outputs", n_out4 - base, 2);
    check("d4_phase_wrap", phase4, 0);

    // 2-bit counter sticks at its maximum.
    for (int k = 0; k < 16; k++) send4(32'h7FFF_FFFF);
    idle();
    tick(8);
    check("d4_sat_stick", sat4, m_sat4);
    check("d4_sat_max", sat4, 3);

    // Backpressure: four accepts, then in_ready low until released.
    @(negedge clk); out_ready = 1'b0;
    base = n_acc1;
    fork
      begin
        for (int k = 1; k <= 6; k++) send1(k * 32768);
        idle();
      end
      begin
        int w;
        w = 0;
        while ((n_acc1 - base) < 4 && w < 50) begin
          @(negedge clk); #1;
          w++;
        end
        tick(3);
        check("d1_bp_accepts", n_acc1 - base, 4);
        check("d1_bp_in_ready", in_ready1, 0);
        @(negedge clk); out_ready = 1'b1;
      end
    join
    tick(12);
    check("d1_bp_drained", q1.size(), 0);

    // Full FIFO, then continuous push with pop.
    @(negedge clk); out_ready = 1'b0;
    for (int k = 1; k <= 4; k++) send1(k * 32768);
    idle();
    repeat (2) @(negedge clk);
    out_ready = 1'b1;
    stalls1 = 0;
    for (int i = 0; i < 30; i++) begin
      r = $urandom();
      x = r[0] ? {{8{r[31]}}, r[31:8]} : r;
      send1(x);
    end
    idle();
    tick(8);
    check("d1_stream_stalls", stalls1, 0);
    check("d1_stream_sat", sat1, m_sat1);

    // Asynchronous reset with three words buffered and one in the pipeline.
    send4(32'd32768);
    idle();
    tick(4);
    check("d4_phase_one", phase4, m_ph4);
    @(negedge clk); out_ready = 1'b0;
    for (int k = 1; k <= 4; k++) send1(k * 32768 + 32'h7000_0000);
    idle();
    #1;
    check("d1_pre_reset_valid", out_valid1, 1);
    #1 rst = 1'b0;
    #1;
    check("arst_d1_out_valid", out_valid1, 0);
    check("arst_d1_out_data", out_data1, 0);
    check("arst_d1_sat", sat1, 0);
    check("arst_d1_phase", phase1, 0);
    check("arst_d4_phase", phase4, 0);
    check("arst_d4_out_valid", out_valid4, 0);
    q1.delete(); q4.delete();
    m_sat1 = 0; m_sat4 = 0; m_ph4 = 0;
    repeat (2) @(negedge clk);
    rst = 1'b1; out_ready = 1'b1;
    lat_chk = 1'b1;
    send1(7 * 32768); send1(-3 * 32768);
    idle();
    tick(5);
    lat_chk = 1'b0;

    tick(4);
    check("d1_final_drain", q1.size(), 0);
    check("d4_final_drain", q4.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fir_decim_requant.md
Name: fir_decim_requant

Overview:
Downstream consumer of the FIR filter's 32-bit signed output stream.
- Keeps one sample in DECIM (the upstream FIR already band-limits the signal).
- Rounds and arithmetic-shifts each kept sample by SHIFT, then saturates it to OUT_W bits.
- Buffers results in a small output FIFO behind a valid/ready handshake and counts saturation events.
- Turns the filter's full-precision accumulator output back into a 16-bit sample stream for the next stage.

Parameters:
IN_W, 32, input sample width (two's complement; matches FIR y_out)
OUT_W, 16, output sample width (two's complement)
SHIFT, 15, right-shift applied after rounding (Q15 coefficient scaling); 1 <= SHIFT < IN_W
DECIM, 4, decimation ratio; 1 = pass every sample
DEPTH, 4, output FIFO depth, power of two, >= 2
CNT_W, 16, saturation counter width

Ports:
clk  in  1  system clock, rising-edge
rst  in  1  asynchronous active-low reset
in_valid  in  1  input sample valid
in_data  in  IN_W  signed FIR output sample
in_ready  out  1  block can accept a sample this cycle
out_valid  out  1  out_data holds a valid sample
out_data  out  OUT_W  signed requantised, decimated sample
out_ready  in  1  downstream accepts out_data this cycle
clr_sat  in  1  synchronous clear of sat_count
sat_count  out  CNT_W  number of kept samples that saturated (sticks at max)
phase  out  ceil(log2(DECIM)) (min 1)  current decimation phase, for debug

Behaviour:
- Reset (rst low, async):
  - phase=0, pipeline valid=0, FIFO empty.
  - out_valid=0, out_data=0, sat_count=0.
  - in_ready=1 from the first edge after release.
  - Reset mid-operation discards all in-flight and buffered samples; no partial output appears after release.
- Input accept: a sample is accepted when in_valid && in_ready at a rising edge.
  - in_ready = (fifo_count + p_valid) < DEPTH.
  - in_ready gates all samples, including ones that will be discarded.
- Decimation:
  - On each accept, phase advances 0..DECIM-1 and wraps to 0.
  - The sample accepted at phase 0 is kept; all others are dropped.
  - With DECIM=1, every sample is kept.
- Stage 1 (edge of accept, kept sample only):
  - r = (in_data + 2^(SHIFT-1)) >>> SHIFT, computed in IN_W+1 bits: arithmetic shift, round-half-up.
  - r is registered with p_valid=1.
- Stage 2 (next edge):
  - s = clamp(r, -2^(OUT_W-1), 2^(OUT_W-1)-1); sat flag = clamping occurred.
  - s is written to the FIFO.
- Latency: a kept sample accepted at edge N is visible on out_data with out_valid=1 after edge N+1, provided the FIFO was empty. This is 2 cycles input-to-output.
- FIFO output:
  - First-word-fall-through; out_data is the registered head.
  - Pop on out_valid && out_ready.
  - out_data holds its value while out_valid && !out_ready.
  - When empty: out_valid=0 and out_data holds its last value.
- Simultaneous push/pop when full: the pop frees a slot, so the push succeeds. The in_ready formula guarantees no overflow; a write into a full FIFO is an assertion failure.
- sat_count:
  - +1 on each stage-2 write with sat flag set.
  - Holds at 2^CNT_W-1.
  - clr_sat has priority: a clear coincident with a saturation yields 0.
- No X on any output after reset; in_data is ignored when in_valid=0.

Decomposition:
- Shared package fir_pkg holds:
  - constants FIR_IN_W=32, FIR_OUT_W=16, FIR_COEF_SHIFT=15;
  - function sat_round(x, shift), returning the clamped value and the sat flag, reused by other requantising stages.
- One sub-module, fir_sync_fifo (parameters: width, depth), with push/pop/full/empty/count.

Test Plan:
1. Reset, DECIM=1, SHIFT=15. Inputs 32768, 16384, -16384, -16385 on consecutive cycles, out_ready=1 -> outputs 1, 1, 0, -1; each appears 2 cycles after its input; sat_count=0.
2. Saturation, DECIM=1. Inputs 0x7FFFFFFF then 0x80000000 -> outputs 32767, -32768; sat_count=2. Pulse clr_sat on the cycle the 3rd saturating input reaches stage 2 -> sat_count=0.
3. Decimation, DECIM=4. Inputs k*32768 for k=1..8, one per cycle -> exactly two outputs, 1 then 5; phase after the run is 0.
4. Backpressure, DECIM=1, DEPTH=4. Hold out_ready=0, in_valid=1 with values 1..6 (times 32768) -> in_ready drops after 4 accepts. Release out_ready -> outputs 1, 2, 3, 4, 5, 6 in order, none lost or duplicated, out_data stable while stalled.
5. Full with simultaneous pop: FIFO full, out_ready=1 and in_valid=1 continuously -> sustained 1 sample/cycle throughput, FIFO count stays at or below DEPTH.
6. Reset mid-stream: assert rst low while the FIFO holds 3 samples and the pipeline holds 1 -> out_valid=0 immediately (async), sat_count=0, phase=0. After release, the first output is the first new kept input.
